// File: rtl/fp_block_accumulator.sv
// Block accumulator: sums N_ACC signed fixed-point samples, re-quantises the
// block total to the output Q-format with saturation, and holds it on a valid/ready port.
module fp_block_accumulator #(
    parameter int W_in    = 16,
    parameter int W_in_F  = 14,
    parameter int W_acc   = 19,
    parameter int N_ACC   = 8,
    parameter int W_out   = 16,
    parameter int W_out_F = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_in-1:0]  in_data,
    input  logic             in_ovf,
    input  logic             in_udf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_out-1:0] out_data,
    output logic             out_sat,
    output logic             out_flag
);

    localparam int CNT_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);

    localparam int SHL   = (W_out_F >= W_in_F) ? (W_out_F - W_in_F) : 0;
    localparam int SHR   = (W_out_F >= W_in_F) ? 0 : (W_in_F - W_out_F);
    localparam int W_EXT = (((W_acc + SHL) > W_out) ? (W_acc + SHL) : W_out) + 1;

    localparam logic signed [W_EXT-1:0] OUT_MAX = {{(W_EXT-W_out+1){1'b0}}, {(W_out-1){1'b1}}};
    localparam logic signed [W_EXT-1:0] OUT_MIN = {{(W_EXT-W_out+1){1'b1}}, {(W_out-1){1'b0}}};

    localparam logic ST_ACC  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    if (W_acc < W_in + $clog2(N_ACC)) begin : g_bad_acc_width
        $error("fp_block_accumulator: W_acc too narrow for N_ACC samples");
    end
    if (N_ACC < 2) begin : g_bad_n_acc
        $error("fp_block_accumulator: N_ACC must be at least 2");
    end

    logic                    state_q, state_d;
    logic signed [W_acc-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sticky_q, sticky_d;
    logic [W_out-1:0]        out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic                    out_flag_q, out_flag_d;

    logic signed [W_acc-1:0] sample_ext;
    logic signed [W_acc-1:0] total;
    logic signed [W_EXT-1:0] total_ext;
    logic signed [W_EXT-1:0] scaled;
    logic [W_out-1:0]        quant_data;
    logic                    quant_sat;
    logic                    accept;
    logic                    sticky_hit;

    // The accumulator is wide enough that total never wraps; W_EXT leaves headroom for the left shift.
    always_comb begin
        sample_ext = {{(W_acc-W_in){in_data[W_in-1]}}, in_data};
        total      = acc_q + sample_ext;
        total_ext  = {{(W_EXT-W_acc){total[W_acc-1]}}, total};
        scaled     = (total_ext <<< SHL) >>> SHR;
        quant_data = scaled[W_out-1:0];
        quant_sat  = 1'b0;
        if (scaled > OUT_MAX) begin
            quant_data = OUT_MAX[W_out-1:0];
            quant_sat  = 1'b1;
        end else if (scaled < OUT_MIN) begin
            quant_data = OUT_MIN[W_out-1:0];
            quant_sat  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        out_flag_d = out_flag_q;
        accept     = in_valid && (state_q == ST_ACC);
        sticky_hit = sticky_q | in_ovf | in_udf;

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        out_data_d = quant_data;
                        out_sat_d  = quant_sat;
                        out_flag_d = sticky_hit;
                        acc_d      = '0;
                        cnt_d      = '0;
                        sticky_d   = 1'b0;
                        state_d    = ST_HOLD;
                    end else begin
                        acc_d    = total;
                        cnt_d    = cnt_q + 1'b1;
                        sticky_d = sticky_hit;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_flag_q <= out_flag_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_flag  = out_flag_q;

endmodule

// File: tb/tb_fp_block_accumulator.sv
// Scoreboard bench for fp_block_accumulator: expected block results are queued
// as blocks are driven and compared whenever a result is handed over.
module tb_fp_block_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_ovf;
    logic        in_udf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_flag;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        logic        flag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_exp_data;
    logic [15:0] blk [8];

    fp_block_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .in_udf    (in_udf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_flag  (out_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Every handed-over result is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(e.data));
                checkOutput("out_sat", 32'(out_sat), 32'(e.sat));
                checkOutput("out_flag", 32'(out_flag), 32'(e.flag));
            end
        end
    end

    task automatic fillBlock(input logic [15:0] value);
        foreach (blk[i]) blk[i] = value;
    endtask

    task automatic driveSample(input logic [15:0] d, input logic ovf, input logic udf, input bit is_last);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = ovf;
        in_udf   = udf;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("accept_timeout", 32'd1, 32'd0);
        if (is_last) checkOutput("valid_before_last", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ovf   = 1'b0;
        in_udf   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] ovf_mask, input logic [7:0] udf_mask, input bit gaps);
        int   total = 0;
        exp_t e;
        e.flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total  += int'($signed(blk[i]));
            e.flag |= ovf_mask[i] | udf_mask[i];
        end
        if (total > 32767) begin
            e.data = 16'h7FFF;
            e.sat  = 1'b1;
        end else if (total < -32768) begin
            e.data = 16'h8000;
            e.sat  = 1'b1;
        end else begin
            e.data = 16'(total);
            e.sat  = 1'b0;
        end
        exp_q.push_back(e);
        last_exp_data = e.data;
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            driveSample(blk[i], ovf_mask[i], udf_mask[i], i == 7);
        end
        @(negedge clk);
        checkOutput("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_ovf    = 1'b0;
        in_udf    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
        checkOutput("rst_out_flag", 32'(out_flag), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] basic 0.125 x 8");
        fillBlock(16'h0800);
        applyStimulus(8'h00, 8'h00, 1'b0);

        $display("[TB] positive and negative saturation");
        fillBlock(16'h2000);
        applyStimulus(8'h00, 8'h00, 1'b0);
        fillBlock(16'hE000);
        applyStimulus(8'h00, 8'h00, 1'b0);

        $display("[TB] exact minimum");
        fillBlock(16'hF000);
        applyStimulus(8'h00, 8'h00, 1'b0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        fillBlock(16'h0800);
        applyStimulus(8'h00, 8'h00, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0800;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_data_stable", 32'(out_data), 32'(last_exp_data));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0);

        $display("[TB] sticky flags");
        applyStimulus(8'h04, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'h80, 1'b0);

        $display("[TB] reset mid-block");
        fillBlock(16'h2000);
        for (int i = 0; i < 4; i++) driveSample(blk[i], 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_out_data", 32'(out_data), 32'd0);
        checkOutput("mid_rst_out_sat", 32'(out_sat), 32'd0);
        checkOutput("mid_rst_out_flag", 32'(out_flag), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        fillBlock(16'h0800);
        applyStimulus(8'h00, 8'h00, 1'b0);

        $display("[TB] random gaps and data");
        applyStimulus(8'h00, 8'h00, 1'b1);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                if (b < 2) blk[i] = 16'($urandom_range(0, 8191)) - 16'd4096;
                else       blk[i] = 16'($urandom);
            end
            applyStimulus(8'($urandom_range(0, 255)) & 8'h11, 8'($urandom_range(0, 255)) & 8'h20, 1'b1);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_block_accumulator.md
Name: fp_block_accumulator

Overview:
- Downstream consumer of the fixed-point adder's registered `sum`, `overflow` and `underflow` outputs.
- Accumulates a block of N_ACC accepted samples into a wide internal register.
- Re-quantises the block total to the output Q-format with saturation.
- Presents each block result on a valid/ready output port with backpressure; a sticky flag carries the adder's overflow/underflow history per block.

Parameters:
W_in, 16, input word width (signed two's complement)
W_in_F, 14, input fractional bits
W_acc, 19, accumulator width; must be >= W_in + clog2(N_ACC) (elaboration check, so no internal wrap)
N_ACC, 8, samples per block (>= 2)
W_out, 16, output word width (signed)
W_out_F, 14, output fractional bits

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input sample valid
in_ready  output  1  block can accept a sample
in_data  input  W_in  signed sample, Q(W_in-W_in_F).W_in_F
in_ovf  input  1  upstream overflow flag for this sample
in_udf  input  1  upstream underflow flag for this sample
out_valid  output  1  block result valid
out_ready  input  1  consumer accepts result
out_data  output  W_out  signed block sum, Q(W_out-W_out_F).W_out_F
out_sat  output  1  out_data was clipped during re-quantisation
out_flag  output  1  at least one sample in the block had in_ovf or in_udf set

Behaviour:
- Reset (asynchronous, any time, including mid-block or while holding a result):
  - state=ACC, acc=0, cnt=0, sticky flag=0.
  - out_valid=0, out_data=0, out_sat=0, out_flag=0.
  - in_ready=1 from the first clock after reset deasserts.
- Two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Handshake:
  - A sample is accepted on a rising edge with in_valid & in_ready.
  - in_valid gaps are allowed; cnt advances only on accepted samples.
- In ACC, on each accepted sample:
  - acc <= acc + sign_ext(in_data).
  - sticky <= sticky | in_ovf | in_udf.
  - cnt <= cnt+1.
- Last sample (accepted with cnt==N_ACC-1), all in the same edge:
  - total = acc + sign_ext(in_data).
  - Re-quantise total, load out_data, out_sat and out_flag (sticky | this sample's flags).
  - Clear acc, cnt and sticky; go to HOLD.
  - Latency: out_valid asserts the cycle after the last sample is accepted.
- In HOLD:
  - out_data, out_sat and out_flag stay stable.
  - in_valid is ignored (no accept).
  - On out_valid & out_ready at an edge, go to ACC. in_ready=1 and out_valid=0 the next cycle.
  - Minimum block period is therefore N_ACC+1 cycles.
- Re-quantisation:
  - If W_out_F >= W_in_F: shift left by (W_out_F-W_in_F).
  - Otherwise: arithmetic right shift by (W_in_F-W_out_F), truncating toward minus infinity.
  - Then saturate to [-2^(W_out-1), 2^(W_out-1)-1].
  - out_sat=1 only when clipping occurs. An exact minimum value such as -2.0 is not clipped.
- out_data and out_sat hold their last values after the handshake until the next block result overwrites them. Consumers qualify them with out_valid.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. Default params, 8 samples of 0x0800 (0.125), out_ready=1 -> out_data=0x4000 (1.0), out_sat=0, out_flag=0, out_valid high exactly 1 cycle after the 8th accept.
2. 8 samples of 0x2000 (0.5) -> total 4.0 (acc 0x10000), out_data=0x7FFF, out_sat=1. Then 8 samples of 0xE000 (-0.5) -> out_data=0x8000, out_sat=1.
3. 8 samples of 0xF000 (-0.25) -> out_data=0x8000 (-2.0), out_sat=0 (exact minimum is not clipped).
4. Backpressure: after a result, out_ready=0 for 5 cycles with in_valid=1 and in_data=0x0800 -> in_ready=0, no samples consumed, out_data stable. Raise out_ready -> next block of 8 accepted samples again gives 0x4000.
5. Flags: in_ovf=1 on sample 3 of a block of 0x0800 -> out_flag=1. The next clean block -> out_flag=0. Repeat with in_udf on the last sample -> out_flag=1.
6. Reset mid-block: accept 4 samples of 0x2000, pulse reset asynchronously between edges -> outputs 0 immediately. A fresh 8 samples of 0x0800 -> 0x4000, confirming acc and cnt were cleared. Also use random in_valid gaps and confirm cnt counts accepts only.
